// File: rtl/apb_regbus_mux_bridge.sv
// apb_regbus_mux_bridge: APB3/APB4 slave fanning one port out to NUM_TGT register-bus targets.
// Optional secure-only target filtering is enabled with APB_REGBUS_SECURE_CHECK_EN.
module apb_regbus_mux_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TGT = 4,
    parameter int TGT_ADDR_BITS = 12,
    parameter int TIMEOUT = 15,
    parameter logic [NUM_TGT-1:0] SECURE_MASK = '0
) (
    input  logic                          clk,
    input  logic                          presetn,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic [2:0]                    pprot,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [TGT_ADDR_BITS-1:0]      rb_addr,
    output logic [DATA_WIDTH-1:0]         rb_wdata,
    output logic [DATA_WIDTH/8-1:0]       rb_wstrb,
    output logic [NUM_TGT-1:0]            rb_rstrobe,
    output logic [NUM_TGT-1:0]            rb_wstrobe,
    input  logic [NUM_TGT*DATA_WIDTH-1:0] rb_rdata,
    input  logic [NUM_TGT-1:0]            rb_rack,
    input  logic [NUM_TGT-1:0]            rb_wack,
    input  logic [NUM_TGT-1:0]            rb_raddrerr,
    input  logic [NUM_TGT-1:0]            rb_waddrerr
);
    localparam int IDX_W = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
    localparam logic [IDX_W:0] NT = (IDX_W + 1)'(NUM_TGT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_in;
    logic                      wr_q, err_q, err_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [TGT_ADDR_BITS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q, prdata_q, prdata_d, sel_rdata;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      pready_q, pready_d, pslverr_q, pslverr_d;
    logic [ADDR_WIDTH-1:0]     hi_bits;
    logic [NUM_TGT-1:0]        stb_v;
    logic                      setup, bad, sec_err, sel_ack, sel_err, done;
    logic                      unused_cfg;

    assign idx_in  = paddr[TGT_ADDR_BITS +: IDX_W];
    assign hi_bits = paddr >> (TGT_ADDR_BITS + IDX_W);
    assign setup   = state_q == IDLE && psel && !penable;
`ifdef APB_REGBUS_SECURE_CHECK_EN
    assign sec_err = pprot[1] && SECURE_MASK[idx_in];
`else
    assign sec_err = 1'b0;
`endif
    assign unused_cfg = ^{pprot, SECURE_MASK};
    assign bad = ({1'b0, idx_in} >= NT) || (|hi_bits) || sec_err;

    // Only the latched target's handshake is ever looked at.
    assign sel_ack   = wr_q ? rb_wack[idx_q] : rb_rack[idx_q];
    assign sel_err   = wr_q ? rb_waddrerr[idx_q] : rb_raddrerr[idx_q];
    assign sel_rdata = rb_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign done      = sel_ack || sel_err;

    // Rejected transfers still pass through STROBE (with no strobe) to keep one wait state.
    assign stb_v      = (state_q == STROBE && !err_q) ? (NUM_TGT'(1) << idx_q) : '0;
    assign rb_wstrobe = wr_q ? stb_v : '0;
    assign rb_rstrobe = wr_q ? '0 : stb_v;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = STROBE;
                    err_d   = bad;
                end
            end
            STROBE, WAIT: begin
                cnt_d = state_q == STROBE ? 8'd0 : cnt_q + 8'd1;
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (state_q == STROBE && err_q) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (done) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    prdata_d  = (!wr_q && sel_ack) ? sel_rdata : '0;
                end else if (state_q == WAIT && cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (setup) begin
                idx_q   <= idx_in;
                wr_q    <= pwrite;
                addr_q  <= paddr[TGT_ADDR_BITS-1:0];
                wdata_q <= pwdata;
                wstrb_q <= pwrite ? pstrb : '1;
            end
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign rb_addr  = addr_q;
    assign rb_wdata = wdata_q;
    assign rb_wstrb = wstrb_q;
endmodule

// File: tb/tb_apb_regbus_mux_bridge.sv
// tb_apb_regbus_mux_bridge: vector table of APB transfers against a behavioural target cluster,
// expected responses queued at SETUP and compared when pready rises.
module tb_apb_regbus_mux_bridge;
    logic         clk = 1'b0;
    logic         presetn;
    logic [15:0]  paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [11:0]  rb_addr;
    logic [31:0]  rb_wdata;
    logic [3:0]   rb_wstrb, rb_rstrobe, rb_wstrobe;
    logic [127:0] rb_rdata;
    logic [3:0]   rb_rack, rb_wack, rb_raddrerr, rb_waddrerr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          dly;
        logic        ack, aerr, noise;
        logic [31:0] rdata;
        logic [31:0] e_prdata;
        logic        e_err;
        int          e_waits;
        logic [3:0]  e_w, e_r;
    } vec_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] prdata;
        logic        err;
        int          waits;
        logic [3:0]  w, r, wstrb;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    vec_t tv[$];
    exp_t sbq[$];

    apb_regbus_mux_bridge #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_TGT(4), .TGT_ADDR_BITS(12),
        .TIMEOUT(15), .SECURE_MASK(4'b0001)
    ) dut (
        .clk(clk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rb_addr(rb_addr), .rb_wdata(rb_wdata), .rb_wstrb(rb_wstrb),
        .rb_rstrobe(rb_rstrobe), .rb_wstrobe(rb_wstrobe), .rb_rdata(rb_rdata),
        .rb_rack(rb_rack), .rb_wack(rb_wack), .rb_raddrerr(rb_raddrerr), .rb_waddrerr(rb_waddrerr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string nm, input logic [15:0] a, input logic w,
                                input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                                input int dly, input logic ack, input logic aerr, input logic nz,
                                input logic [31:0] rd, input logic [31:0] ep, input logic ee,
                                input int ew, input logic [3:0] ewv, input logic [3:0] erv);
        vec_t v;
        v.name = nm; v.addr = a; v.wr = w; v.wdata = wd; v.strb = st; v.prot = pr;
        v.dly = dly; v.ack = ack; v.aerr = aerr; v.noise = nz; v.rdata = rd;
        v.e_prdata = ep; v.e_err = ee; v.e_waits = ew; v.e_w = ewv; v.e_r = erv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_acks();
        rb_rack = '0; rb_wack = '0; rb_raddrerr = '0; rb_waddrerr = '0;
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int t, d, waits, sn;
        logic [3:0] sw, sr, ss, nz;
        logic [11:0] sa;
        logic [31:0] sd;
        bit done;
        t  = int'(v.addr[13:12]);
        nz = v.noise ? ~(4'b0001 << t) : 4'b0000;
        @(negedge clk);
        paddr = v.addr; pwrite = v.wr; pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
        psel = 1'b1; penable = 1'b0;
        for (int i = 0; i < 4; i++) rb_rdata[i*32 +: 32] = (i == t) ? v.rdata : ~v.rdata;
        e.name = v.name; e.wr = v.wr; e.prdata = v.e_prdata; e.err = v.e_err; e.waits = v.e_waits;
        e.w = v.e_w; e.r = v.e_r; e.addr = v.addr[11:0]; e.wstrb = v.wr ? v.strb : 4'hF; e.wdata = v.wdata;
        sbq.push_back(e);
        d = -1; waits = 0; sn = 0; sw = '0; sr = '0; ss = '0; sa = '0; sd = '0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            penable = 1'b1;
            rb_rack = nz; rb_wack = nz; rb_raddrerr = nz; rb_waddrerr = nz;
            if (pready) begin
                done = 1'b1;
                e = sbq.pop_front();
                chk({e.name, "_prdata"}, prdata, e.prdata);
                chk({e.name, "_pslverr"}, 32'(pslverr), 32'(e.err));
                chk({e.name, "_waits"}, waits, e.waits);
                chk({e.name, "_wstrobe"}, 32'(sw), 32'(e.w));
                chk({e.name, "_rstrobe"}, 32'(sr), 32'(e.r));
                chk({e.name, "_strobe_cycles"}, sn, (|(e.w | e.r)) ? 32'd1 : 32'd0);
                if (sn != 0) begin
                    chk({e.name, "_rb_addr"}, 32'(sa), 32'(e.addr));
                    chk({e.name, "_rb_wstrb"}, 32'(ss), 32'(e.wstrb));
                    if (e.wr) chk({e.name, "_rb_wdata"}, sd, e.wdata);
                end
            end else begin
                waits++;
                if (|(rb_wstrobe | rb_rstrobe)) begin
                    sw |= rb_wstrobe; sr |= rb_rstrobe; sn++;
                    sa = rb_addr; ss = rb_wstrb; sd = rb_wdata;
                    if (v.dly >= 0) d = v.dly;
                end
                if (d == 0) begin
                    if (v.ack) begin rb_rack[t] = !v.wr; rb_wack[t] = v.wr; end
                    if (v.aerr) begin rb_raddrerr[t] = !v.wr; rb_waddrerr[t] = v.wr; end
                end
                if (d >= 0) d--;
            end
        end
        if (!done) begin
            checks++; errors++;
            e = sbq.pop_front();
            $display("FAIL %s_timeout: got no pready, expected pready within 40 cycles", e.name);
        end
        psel = 1'b0; penable = 1'b0;
        clear_acks();
    endtask

    task automatic start_read(input logic [15:0] a);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; pprot = 3'b000; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
    endtask

    initial begin
        logic [31:0] seen;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; rb_rdata = '0;
        clear_acks();

        tv.push_back(mk("wr_t2",       16'h2010, 1, 32'hDEADBEEF, 4'b0011, 3'b000, 1, 1, 0, 0, 32'h77777777, 32'h0, 0, 2, 4'b0100, 4'b0000));
        tv.push_back(mk("rd_t1",       16'h1004, 0, 32'h0,        4'b0000, 3'b000, 3, 1, 0, 0, 32'h12345678, 32'h12345678, 0, 4, 4'b0000, 4'b0010));
        tv.push_back(mk("dec_err",     16'h4000, 0, 32'h0,        4'b0000, 3'b000, -1, 0, 0, 0, 32'h55AA55AA, 32'h0, 1, 1, 4'b0000, 4'b0000));
        tv.push_back(mk("timeout",     16'h0FFC, 0, 32'h0,        4'b0000, 3'b000, -1, 0, 0, 0, 32'h11112222, 32'h0, 1, 16, 4'b0000, 4'b0001));
        tv.push_back(mk("rd_aerr_t3",  16'h3008, 0, 32'h0,        4'b0000, 3'b000, 0, 1, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 4'b0000, 4'b1000));
        tv.push_back(mk("b2b_wr_t0",   16'h0000, 1, 32'h0BADF00D, 4'b1111, 3'b000, 0, 1, 0, 0, 32'h77777777, 32'h0, 0, 1, 4'b0001, 4'b0000));
        tv.push_back(mk("wr_aerr_only",16'h1100, 1, 32'h00000001, 4'b0101, 3'b000, 2, 0, 1, 0, 32'h77777777, 32'h0, 1, 3, 4'b0010, 4'b0000));
        tv.push_back(mk("rd_noise_t2", 16'h2ABC, 0, 32'h0,        4'b0000, 3'b000, 2, 1, 0, 1, 32'h89ABCDEF, 32'h89ABCDEF, 0, 3, 4'b0000, 4'b0100));
        tv.push_back(mk("wr_noise_t3", 16'h3FFF, 1, 32'hFFFF0000, 4'b1000, 3'b000, 0, 1, 0, 1, 32'h77777777, 32'h0, 0, 1, 4'b1000, 4'b0000));
        tv.push_back(mk("dec_err_wr",  16'h8000, 1, 32'h12121212, 4'b1111, 3'b000, -1, 0, 0, 0, 32'h77777777, 32'h0, 1, 1, 4'b0000, 4'b0000));
`ifdef APB_REGBUS_SECURE_CHECK_EN
        tv.push_back(mk("sec_ns_t0",   16'h0020, 1, 32'hA5A5A5A5, 4'b1111, 3'b010, 0, 1, 0, 0, 32'h77777777, 32'h0, 1, 1, 4'b0000, 4'b0000));
`else
        tv.push_back(mk("sec_ns_t0",   16'h0020, 1, 32'hA5A5A5A5, 4'b1111, 3'b010, 0, 1, 0, 0, 32'h77777777, 32'h0, 0, 1, 4'b0001, 4'b0000));
`endif
        tv.push_back(mk("sec_s_t0",    16'h0020, 1, 32'h5A5A5A5A, 4'b1111, 3'b000, 0, 1, 0, 0, 32'h77777777, 32'h0, 0, 1, 4'b0001, 4'b0000));
        tv.push_back(mk("ns_t1",       16'h1020, 0, 32'h0,        4'b0000, 3'b010, 1, 1, 0, 0, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 2, 4'b0000, 4'b0010));

        repeat (2) @(negedge clk);
        chk("reset_pready", 32'(pready), 32'h0);
        chk("reset_pslverr", 32'(pslverr), 32'h0);
        chk("reset_prdata", prdata, 32'h0);
        chk("reset_strobes", 32'({rb_wstrobe, rb_rstrobe}), 32'h0);
        chk("reset_rb_bus", 32'(rb_addr) | rb_wdata | 32'(rb_wstrb), 32'h0);
        presetn = 1'b1;

        foreach (tv[i]) run(tv[i]);

        // Late acknowledge after a timeout must not disturb anything.
        run(tv[3]);
        seen = '0;
        @(negedge clk);
        @(negedge clk);
        rb_rack = 4'b0001; rb_rdata[31:0] = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rb_rack = '0;
            seen |= prdata | 32'(pready) | 32'(pslverr) | 32'({rb_wstrobe, rb_rstrobe});
        end
        chk("late_ack_quiet", seen, 32'h0);

        // psel dropped mid-WAIT: no pready, and the next transfer times out normally.
        start_read(16'h2000);
        repeat (5) @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        seen = '0;
        repeat (4) begin @(negedge clk); seen |= 32'(pready); end
        chk("abort_no_pready", seen, 32'h0);
        run(tv[3]);

        // Reset during WAIT clears outputs at once; the next transfer succeeds.
        start_read(16'h1000);
        chk("rst_pre_rstrobe", 32'(rb_rstrobe), 32'h2);
        repeat (2) @(negedge clk);
        presetn = 1'b0;
        #1;
        chk("rst_wait_pready", 32'(pready), 32'h0);
        chk("rst_wait_outputs", prdata | 32'(pslverr) | 32'(rb_addr) | 32'({rb_wstrobe, rb_rstrobe}), 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        presetn = 1'b1;
        run(tv[1]);

        // Reset while the strobe is high drops it asynchronously.
        start_read(16'h2000);
        chk("rst_strobe_pre", 32'(rb_rstrobe), 32'h4);
        presetn = 1'b0;
        #1;
        chk("rst_strobe_drop", 32'({rb_wstrobe, rb_rstrobe}), 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        presetn = 1'b1;
        run(tv[0]);

        chk("scoreboard_empty", sbq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
